// File: rtl/dpram_be_pipe_if.sv
// Bus bundle for dpram_be_pipe: two independent request ports (A and B),
// their read returns, and the per-cycle status pulses.
interface dpram_be_pipe_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);
  logic                  en_a;
  logic                  wren_a;
  logic [AWIDTH-1:0]     address_a;
  logic [DWIDTH/8-1:0]   byteen_a;
  logic [DWIDTH-1:0]     data_a;
  logic [DWIDTH-1:0]     out_a;
  logic                  valid_a;

  logic                  en_b;
  logic                  wren_b;
  logic [AWIDTH-1:0]     address_b;
  logic [DWIDTH/8-1:0]   byteen_b;
  logic [DWIDTH-1:0]     data_b;
  logic [DWIDTH-1:0]     out_b;
  logic                  valid_b;

  logic                  collision;
  logic [1:0]            addr_err;

  // Requester side.
  modport master (
    output en_a, wren_a, address_a, byteen_a, data_a,
    output en_b, wren_b, address_b, byteen_b, data_b,
    input  out_a, valid_a, out_b, valid_b, collision, addr_err
  );

  // Memory side.
  modport slave (
    input  en_a, wren_a, address_a, byteen_a, data_a,
    input  en_b, wren_b, address_b, byteen_b, data_b,
    output out_a, valid_a, out_b, valid_b, collision, addr_err
  );
endinterface

// File: rtl/dpram_be_pipe.sv
// True dual-port RAM with per-byte write enables, a READ_LATENCY-deep read
// pipeline per port, selectable read-during-write result, and pulses for
// write/write address collisions and out-of-range requests.
module dpram_be_pipe #(
  parameter int    AWIDTH       = 10,
  parameter int    NUM_WORDS    = 1024,
  parameter int    DWIDTH       = 32,
  parameter int    READ_LATENCY = 1,
  parameter int    RDW_MODE     = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic           clk,
  input  logic           reset,
  dpram_be_pipe_if.slave bus
);
  localparam int              NB    = DWIDTH / 8;
  localparam int              LAT   = READ_LATENCY;
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH + 1)'(NUM_WORDS);

  logic [DWIDTH-1:0] mem_q [NUM_WORDS];

  // Port-indexed views of the bus (index 0 = A, 1 = B).
  logic              en     [2];
  logic              wren   [2];
  logic [AWIDTH-1:0] addr   [2];
  logic [NB-1:0]     byteen [2];
  logic [DWIDTH-1:0] wdata  [2];

  assign en[0]     = bus.en_a;
  assign wren[0]   = bus.wren_a;
  assign addr[0]   = bus.address_a;
  assign byteen[0] = bus.byteen_a;
  assign wdata[0]  = bus.data_a;
  assign en[1]     = bus.en_b;
  assign wren[1]   = bus.wren_b;
  assign addr[1]   = bus.address_b;
  assign byteen[1] = bus.byteen_b;
  assign wdata[1]  = bus.data_b;

  logic              in_range [2];
  logic              wr_en    [2];
  logic              rd_en    [2];
  logic [NB-1:0]     be_lin   [2];   // be_lin[j] enables byte lane j (bits 8j+7:8j)
  logic [DWIDTH-1:0] rd_word  [2];

  logic              vld_q [2][LAT];
  logic              vld_d [2][LAT];
  logic [DWIDTH-1:0] dat_q [2][LAT];
  logic [DWIDTH-1:0] dat_d [2][LAT];

  logic              collision_q, collision_d;
  logic [1:0]        addr_err_q,  addr_err_d;

  // Decode each request: range check, access type, and byte-lane order
  // (byteen MSB controls the lowest byte lane).
  always_comb begin
    // NOTE: every combinational output gets a default before any condition so no latch is inferred.
    for (int p = 0; p < 2; p++) begin
      be_lin[p]   = '0;
      in_range[p] = ({1'b0, addr[p]} < DEPTH);
      wr_en[p]    = en[p] & wren[p] & in_range[p];
      rd_en[p]    = en[p] & ~wren[p];
      for (int j = 0; j < NB; j++) begin
        be_lin[p][j] = byteen[p][NB-1-j];
      end
    end
  end

  // Read word per port: zero when out of range; in new-data mode the other
  // port's same-cycle write bytes are merged over the stored word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range[p]) begin
        rd_word[p] = mem_q[addr[p]];
        if (RDW_MODE == 1 && wr_en[1-p] && addr[1-p] == addr[p]) begin
          for (int j = 0; j < NB; j++) begin
            if (be_lin[1-p][j]) rd_word[p][8*j +: 8] = wdata[1-p][8*j +: 8];
          end
        end
      end
    end
  end

  // Byte-lane writes; port B first so port A's bytes win on a shared address.
  // NOTE: the array has no reset branch so it maps onto block RAM and keeps contents across reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NB; j++) begin
      if (wr_en[1] && be_lin[1][j]) mem_q[addr[1]][8*j +: 8] <= wdata[1][8*j +: 8];
      if (wr_en[0] && be_lin[0][j]) mem_q[addr[0]][8*j +: 8] <= wdata[0][8*j +: 8];
    end
  end

  // Read pipeline next state: valid shifts every cycle, data only moves with
  // a valid so the last stage holds the most recent read result.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      vld_d[p][0] = rd_en[p];
      dat_d[p][0] = rd_en[p] ? rd_word[p] : dat_q[p][0];
      for (int s = 1; s < LAT; s++) begin
        vld_d[p][s] = vld_q[p][s-1];
        dat_d[p][s] = vld_q[p][s-1] ? dat_q[p][s-1] : dat_q[p][s];
      end
    end
    collision_d = wr_en[0] & wr_en[1] & (addr[0] == addr[1]);
    addr_err_d  = {en[1] & ~in_range[1], en[0] & ~in_range[0]};
  end

  // Pipeline and status registers; reset drops every read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < LAT; s++) begin
          vld_q[p][s] <= 1'b0;
          dat_q[p][s] <= '0;
        end
      end
      collision_q <= 1'b0;
      addr_err_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < LAT; s++) begin
          vld_q[p][s] <= vld_d[p][s];
          dat_q[p][s] <= dat_d[p][s];
        end
      end
      collision_q <= collision_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign bus.out_a     = dat_q[0][LAT-1];
  assign bus.valid_a   = vld_q[0][LAT-1];
  assign bus.out_b     = dat_q[1][LAT-1];
  assign bus.valid_b   = vld_q[1][LAT-1];
  assign bus.collision = collision_q;
  assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_dpram_be_pipe.sv
// Bench for dpram_be_pipe. Two instances run side by side on the same
// stimulus: dut0 (32-bit, latency 1, old-data RDW, 1000 words) and
// dut1 (64-bit, latency 3, new-data RDW, 1024 words). A byte-level model
// predicts every output each cycle; a constant vector table and a few
// directed sequences pin the documented examples.
module tb_dpram_be_pipe;
  typedef struct packed {
    logic        en;
    logic        wren;
    logic [9:0]  addr;
    logic [7:0]  be;
    logic [63:0] data;
  } op_t;

  typedef struct {
    op_t         a;
    op_t         b;
    logic        va;
    logic [31:0] oa;
    logic        vb;
    logic [31:0] ob;
    logic        col;
    logic [1:0]  err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dpram_be_pipe_if #(.AWIDTH(10), .DWIDTH(32)) if0 ();
  dpram_be_pipe_if #(.AWIDTH(10), .DWIDTH(64)) if1 ();

  dpram_be_pipe #(.AWIDTH(10), .NUM_WORDS(1000), .DWIDTH(32), .READ_LATENCY(1),
                  .RDW_MODE(0), .INIT_FILE("")) dut0 (.clk(clk), .reset(reset), .bus(if0));
  dpram_be_pipe #(.AWIDTH(10), .NUM_WORDS(1024), .DWIDTH(64), .READ_LATENCY(3),
                  .RDW_MODE(1), .INIT_FILE("")) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [63:0] mem_m   [2][1024];
  logic        hv      [2][2][8];   // read issued at step (ring by step number)
  logic [63:0] hd      [2][2][8];   // data that read should return
  logic [63:0] exp_out [2][2];
  logic        exp_col [2];
  logic [1:0]  exp_err [2];
  int          sc = 0;              // step counter
  int          rst_step = 0;        // first step whose reads survive the last reset

  function automatic int nb_of(int d);  return (d == 0) ? 4 : 8;       endfunction
  function automatic int lat_of(int d); return (d == 0) ? 1 : 3;       endfunction
  function automatic int nw_of(int d);  return (d == 0) ? 1000 : 1024; endfunction
  function automatic int rdw_of(int d); return (d == 0) ? 0 : 1;       endfunction

  function automatic op_t mk(logic en, logic wr, int addr, logic [7:0] be, logic [63:0] data);
    op_t o;
    o.en = en; o.wren = wr; o.addr = addr[9:0]; o.be = be; o.data = data;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input op_t a, input op_t b);
    if0.en_a = a.en; if0.wren_a = a.wren; if0.address_a = a.addr;
    if0.byteen_a = a.be[3:0]; if0.data_a = a.data[31:0];
    if0.en_b = b.en; if0.wren_b = b.wren; if0.address_b = b.addr;
    if0.byteen_b = b.be[3:0]; if0.data_b = b.data[31:0];
    if1.en_a = a.en; if1.wren_a = a.wren; if1.address_a = a.addr;
    if1.byteen_a = a.be; if1.data_a = a.data;
    if1.en_b = b.en; if1.wren_b = b.wren; if1.address_b = b.addr;
    if1.byteen_b = b.be; if1.data_b = b.data;
  endtask

  // One clock cycle: apply ops, predict, clock, compare all outputs of both DUTs.
  task automatic step(input op_t a, input op_t b);
    op_t         op [2];
    logic        inr [2];
    logic        wr [2];
    logic [7:0]  be_m [2];
    logic [63:0] dat_m [2];
    logic [63:0] rv;
    logic        act_v [2][2];
    logic [63:0] act_o [2][2];
    logic        act_c [2];
    logic [1:0]  act_e [2];
    int nb, q, src, slot;
    logic ev;
    op[0] = a; op[1] = b;
    drive(a, b);
    slot = sc % 8;
    for (int d = 0; d < 2; d++) begin
      nb = nb_of(d);
      for (int p = 0; p < 2; p++) begin
        be_m[p]  = (d == 0) ? {4'h0, op[p].be[3:0]} : op[p].be;
        dat_m[p] = (d == 0) ? {32'h0, op[p].data[31:0]} : op[p].data;
        inr[p]   = (int'(op[p].addr) < nw_of(d));
        wr[p]    = op[p].en && op[p].wren && inr[p];
      end
      exp_col[d] = wr[0] && wr[1] && (op[0].addr == op[1].addr);
      exp_err[d] = {op[1].en && !inr[1], op[0].en && !inr[0]};
      // Reads see the memory before this cycle's writes, plus the other
      // port's bytes when the instance returns new data.
      for (int p = 0; p < 2; p++) begin
        q  = 1 - p;
        rv = 64'h0;
        if (op[p].en && !op[p].wren && inr[p]) begin
          rv = mem_m[d][op[p].addr];
          if (rdw_of(d) == 1 && wr[q] && op[q].addr == op[p].addr)
            for (int j = 0; j < nb; j++)
              if (be_m[q][nb-1-j]) rv[8*j +: 8] = dat_m[q][8*j +: 8];
        end
        hv[d][p][slot] = op[p].en && !op[p].wren;
        hd[d][p][slot] = rv;
      end
      // Port B bytes first, then port A, so A owns any shared byte.
      for (int p = 1; p >= 0; p--)
        if (wr[p])
          for (int j = 0; j < nb; j++)
            if (be_m[p][nb-1-j]) mem_m[d][op[p].addr][8*j +: 8] = dat_m[p][8*j +: 8];
    end

    @(posedge clk);
    #1;
    act_v[0][0] = if0.valid_a; act_o[0][0] = {32'h0, if0.out_a};
    act_v[0][1] = if0.valid_b; act_o[0][1] = {32'h0, if0.out_b};
    act_v[1][0] = if1.valid_a; act_o[1][0] = if1.out_a;
    act_v[1][1] = if1.valid_b; act_o[1][1] = if1.out_b;
    act_c[0] = if0.collision; act_e[0] = if0.addr_err;
    act_c[1] = if1.collision; act_e[1] = if1.addr_err;
    for (int d = 0; d < 2; d++) begin
      src = sc - lat_of(d) + 1;
      for (int p = 0; p < 2; p++) begin
        ev = 1'b0;
        if (src >= rst_step) begin
          ev = hv[d][p][src % 8];
          if (ev) exp_out[d][p] = hd[d][p][src % 8];
        end
        check($sformatf("dut%0d step%0d valid_%s", d, sc, p == 0 ? "a" : "b"),
              64'(act_v[d][p]), 64'(ev));
        check($sformatf("dut%0d step%0d out_%s", d, sc, p == 0 ? "a" : "b"),
              act_o[d][p], exp_out[d][p]);
      end
      check($sformatf("dut%0d step%0d collision", d, sc), 64'(act_c[d]), 64'(exp_col[d]));
      check($sformatf("dut%0d step%0d addr_err", d, sc), 64'(act_e[d]), 64'(exp_err[d]));
    end
    sc++;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    op_t idle;
    idle = mk(0, 0, 0, 8'h00, 64'h0);
    drive(idle, idle);
    #1 reset = 1'b1;
    #1;
    check("rst dut0 valid_a", 64'(if0.valid_a), 64'h0);
    check("rst dut0 out_a", 64'(if0.out_a), 64'h0);
    check("rst dut0 valid_b", 64'(if0.valid_b), 64'h0);
    check("rst dut0 out_b", 64'(if0.out_b), 64'h0);
    check("rst dut0 collision", 64'(if0.collision), 64'h0);
    check("rst dut0 addr_err", 64'(if0.addr_err), 64'h0);
    check("rst dut1 valid_a", 64'(if1.valid_a), 64'h0);
    check("rst dut1 out_a", if1.out_a, 64'h0);
    check("rst dut1 valid_b", 64'(if1.valid_b), 64'h0);
    check("rst dut1 out_b", if1.out_b, 64'h0);
    check("rst dut1 collision", 64'(if1.collision), 64'h0);
    check("rst dut1 addr_err", 64'(if1.addr_err), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    rst_step = sc;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) exp_out[d][p] = 64'h0;
  endtask

  vec_t tbl [16];

  initial begin
    op_t idle, ra, rb;
    int vcnt, first, last;
    idle = mk(0, 0, 0, 8'h00, 64'h0);

    // Vectors checked against dut0 (32-bit, latency 1, old data, 1000 words).
    tbl[0]  = '{mk(1,1,5,8'hF,64'h11223344),   idle, 0, 32'h0,        0, 32'h0,        0, 2'b00};
    tbl[1]  = '{mk(1,0,5,8'h0,64'h0),          idle, 1, 32'h11223344, 0, 32'h0,        0, 2'b00};
    tbl[2]  = '{idle,                          idle, 0, 32'h11223344, 0, 32'h0,        0, 2'b00};
    tbl[3]  = '{mk(1,1,5,8'h8,64'hAABBCCDD),   idle, 0, 32'h11223344, 0, 32'h0,        0, 2'b00};
    tbl[4]  = '{mk(1,0,5,8'h0,64'h0),          idle, 1, 32'h112233DD, 0, 32'h0,        0, 2'b00};
    tbl[5]  = '{mk(1,1,5,8'h0,64'hFFFFFFFF),   idle, 0, 32'h112233DD, 0, 32'h0,        0, 2'b00};
    tbl[6]  = '{mk(1,0,5,8'h0,64'h0),          idle, 1, 32'h112233DD, 0, 32'h0,        0, 2'b00};
    tbl[7]  = '{mk(1,1,9,8'h3,64'hFFFF0000), mk(1,1,9,8'hF,64'h0000FFFF),
                                                     0, 32'h112233DD, 0, 32'h0,        1, 2'b00};
    tbl[8]  = '{mk(1,0,9,8'h0,64'h0),          idle, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 2'b00};
    tbl[9]  = '{mk(1,1,3,8'hF,64'h00000001),   idle, 0, 32'hFFFFFFFF, 0, 32'h0,        0, 2'b00};
    tbl[10] = '{mk(1,0,3,8'h0,64'h0), mk(1,1,3,8'hF,64'hCAFEF00D),
                                                     1, 32'h00000001, 0, 32'h0,        0, 2'b00};
    tbl[11] = '{idle, mk(1,0,3,8'h0,64'h0),          0, 32'h00000001, 1, 32'hCAFEF00D, 0, 2'b00};
    tbl[12] = '{mk(1,1,1000,8'hF,64'hDEADBEEF), idle, 0, 32'h00000001, 0, 32'hCAFEF00D, 0, 2'b01};
    tbl[13] = '{mk(1,0,1000,8'h0,64'h0), mk(1,0,9,8'h0,64'h0),
                                                     1, 32'h0,        1, 32'hFFFFFFFF, 0, 2'b01};
    tbl[14] = '{mk(1,1,998,8'hF,64'h12345678), mk(1,1,998,8'h0,64'h0),
                                                     0, 32'h0,        0, 32'hFFFFFFFF, 1, 2'b00};
    tbl[15] = '{mk(1,0,998,8'h0,64'h0), mk(1,0,1023,8'h0,64'h0),
                                                     1, 32'h12345678, 1, 32'h0,        0, 2'b10};

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) exp_out[d][p] = 64'h0;

    do_reset();

    // Fill every word on both instances (A even, B odd); 1000+ is out of range for dut0.
    for (int i = 0; i < 512; i++)
      step(mk(1, 1, 2*i, 8'hFF, {$urandom, $urandom}),
           mk(1, 1, 2*i+1, 8'hFF, {$urandom, $urandom}));

    // Contents must survive reset; the table then starts from cleared outputs.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].b);
      check($sformatf("tbl[%0d] valid_a", i), 64'(if0.valid_a), 64'(tbl[i].va));
      check($sformatf("tbl[%0d] out_a", i), 64'(if0.out_a), 64'(tbl[i].oa));
      check($sformatf("tbl[%0d] valid_b", i), 64'(if0.valid_b), 64'(tbl[i].vb));
      check($sformatf("tbl[%0d] out_b", i), 64'(if0.out_b), 64'(tbl[i].ob));
      check($sformatf("tbl[%0d] collision", i), 64'(if0.collision), 64'(tbl[i].col));
      check($sformatf("tbl[%0d] addr_err", i), 64'(if0.addr_err), 64'(tbl[i].err));
    end

    // 64-bit partial write: byteen 8'h0F updates only the upper 32 bits.
    step(mk(1, 1, 20, 8'hFF, 64'h0123456789ABCDEF), idle);
    step(mk(1, 1, 20, 8'h0F, 64'hAAAAAAAABBBBBBBB), idle);
    step(mk(1, 0, 20, 8'h00, 64'h0), idle);
    for (int i = 0; i < 3; i++) step(idle, idle);
    check("dut1 be 0F upper half", if1.out_a, 64'hAAAAAAAA89ABCDEF);

    // Read-during-write, same address: dut0 returns old, dut1 returns new.
    step(mk(1, 1, 3, 8'hFF, 64'h1), idle);
    step(mk(1, 0, 3, 8'h00, 64'h0), mk(1, 1, 3, 8'hFF, 64'hCAFEF00D));
    for (int i = 0; i < 3; i++) step(idle, idle);
    check("dut0 rdw old data", 64'(if0.out_a), 64'h1);
    check("dut1 rdw new data", if1.out_a, 64'hCAFEF00D);

    // Latency-3 burst of 8 reads: valid for 8 consecutive cycles from the third.
    vcnt = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      step((i < 8) ? mk(1, 0, i, 8'h00, 64'h0) : idle, idle);
      if (if1.valid_a) begin
        vcnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("dut1 burst valid count", 64'(vcnt), 64'd8);
    check("dut1 burst first valid", 64'(first), 64'd2);
    check("dut1 burst last valid", 64'(last), 64'd9);

    // Reset mid-burst: no stale valids may follow the release.
    for (int i = 0; i < 5; i++) step(mk(1, 0, i, 8'h00, 64'h0), idle);
    do_reset();
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(idle, idle);
      if (if1.valid_a) vcnt++;
    end
    check("dut1 valids after mid-burst reset", 64'(vcnt), 64'd0);

    // Random traffic concentrated on a few hot addresses and the range boundary.
    for (int i = 0; i < 2500; i++) begin
      op_t o [2];
      for (int p = 0; p < 2; p++) begin
        int sel, ad;
        sel = $urandom_range(0, 3);
        ad  = (sel == 1) ? $urandom_range(996, 1003) :
              (sel == 2) ? $urandom_range(0, 1023) : $urandom_range(0, 7);
        o[p] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ad,
                  8'($urandom), {$urandom, $urandom});
      end
      ra = o[0]; rb = o[1];
      step(ra, rb);
      if (i == 1200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
